i2c_engine: RTL

I2C_ENGINE -- requirements
Module: i2c_engine

---
 rtl/i2c_engine.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/i2c_engine.sv
// i2c_engine: byte-level I2C master bit engine.
// A client issues one instruction at a time (START, STOP, READ_BYTE, WRITE_BYTE)
// with an enable/complete handshake. Each bit is four quarters of CLK_DIV clocks.
// scl and sda_oe are registered decodes of the quarter/bit position, so the bus
// pins trail the internal position by one clock. complete trails DONE the same way.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for enable; latches instruction and operands on accept
// START | one bit time generating a (repeated) start condition
// STOP  | one bit time generating a stop condition, bus left idle
// WRITE | 8 data bits from byteToSend MSB first, then slave ACK bit
// READ  | 8 data bits sampled from sda_in MSB first, then master ACK/NACK
// DONE  | instruction finished; waits for enable low before IDLE

module i2c_engine #(
    parameter int CLK_DIV = 67
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] instruction,
    input  logic       enable,
    input  logic [7:0] byteToSend,
    input  logic       readAck,
    output logic [7:0] byteReceived,
    output logic       ackReceived,
    output logic       complete,
    output logic       scl,
    output logic       sda_oe,
    input  logic       sda_in
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        STOP  = 3'd2,
        WRITE = 3'd3,
        READ  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [7:0] QTR_LAST = 8'(CLK_DIV - 1);

    state_t     state;
    logic [1:0] qtr;
    logic [7:0] cnt;
    logic [3:0] bitn;
    logic [7:0] tx_shift;
    logic [7:0] rx_shift;
    logic       rack;

    logic       qtr_end;
    logic       bit_end;
    logic       sample_pt;
    logic       scl_nxt;
    logic       sda_nxt;

    // Position decode and bus-pin targets for the current quarter/bit.
    always_comb begin
        qtr_end   = (cnt == QTR_LAST);
        bit_end   = qtr_end && (qtr == 2'd3);
        sample_pt = qtr_end && (qtr == 2'd1);
        scl_nxt   = scl;
        sda_nxt   = sda_oe;
        case (state)
            START: begin
                scl_nxt = (qtr == 2'd1) || (qtr == 2'd2);
                sda_nxt = qtr[1];
            end
            STOP: begin
                scl_nxt = (qtr != 2'd0);
                sda_nxt = ~qtr[1];
            end
            WRITE: begin
                scl_nxt = qtr[0] ^ qtr[1];
                // 9th bit (bitn == 8) releases SDA for the slave ACK.
                sda_nxt = bitn[3] ? 1'b0 : ~tx_shift[7];
            end
            READ: begin
                scl_nxt = qtr[0] ^ qtr[1];
                sda_nxt = bitn[3] ? rack : 1'b0;
            end
            default: begin
            end
        endcase
    end

    // Sequencer: handshake, quarter/bit counters, shift registers and pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            qtr          <= 2'd0;
            cnt          <= 8'd0;
            bitn         <= 4'd0;
            tx_shift     <= 8'd0;
            rx_shift     <= 8'd0;
            rack         <= 1'b0;
            byteReceived <= 8'd0;
            ackReceived  <= 1'b0;
            complete     <= 1'b0;
            scl          <= 1'b1;
            sda_oe       <= 1'b0;
        end else begin
            complete <= (state == DONE);
            // Outside execution states the pins hold, so the bus stays where
            // the last instruction left it.
            scl      <= scl_nxt;
            sda_oe   <= sda_nxt;
            case (state)
                IDLE: begin
                    if (enable) begin
                        tx_shift <= byteToSend;
                        rack     <= readAck;
                        cnt      <= 8'd0;
                        qtr      <= 2'd0;
                        bitn     <= 4'd0;
                        case (instruction)
                            2'd0:    state <= START;
                            2'd1:    state <= STOP;
                            2'd2:    state <= READ;
                            default: state <= WRITE;
                        endcase
                    end
                end
                START, STOP, WRITE, READ: begin
                    if (sample_pt && (state == WRITE) && bitn[3]) begin
                        ackReceived <= ~sda_in;
                    end
                    if (sample_pt && (state == READ) && !bitn[3]) begin
                        rx_shift <= {rx_shift[6:0], sda_in};
                    end
                    if (qtr_end) begin
                        cnt <= 8'd0;
                        qtr <= qtr + 2'd1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                    if (bit_end) begin
                        if ((state == START) || (state == STOP) || bitn[3]) begin
                            state <= DONE;
                            if (state == READ) begin
                                byteReceived <= rx_shift;
                            end
                        end else begin
                            bitn     <= bitn + 4'd1;
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end
                    end
                end
                DONE: begin
                    if (!enable) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
